// File: rtl/gfx_pkg.sv
// Shared graphics constants and types for the frame scheduler and the
// framebuffer address path.
package gfx_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int FB_AW     = 19;
    localparam int COLOR_W   = 8;
    localparam int FB_PIXELS = H_RES * V_RES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DRAW_START,
        S_DRAW_WAIT,
        S_READY
    } sched_state_t;

    typedef logic [COLOR_W-1:0] pixel_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational (x, y) -> linear framebuffer address, plus a flag telling
// whether the coordinate lies inside the visible frame.
module fb_addr_gen #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int FB_AW = 19
) (
    input  logic [9:0]       x_i,
    input  logic [9:0]       y_i,
    output logic [FB_AW-1:0] addr_o,
    output logic             in_range_o
);

    // Full 32-bit product first; the range check guarantees it fits FB_AW
    // whenever in_range_o is set.
    assign addr_o     = FB_AW'(32'(y_i) * 32'(H_RES) + 32'(x_i));
    assign in_range_o = (32'(x_i) < 32'(H_RES)) && (32'(y_i) < 32'(V_RES));

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: swap buffers, clear the back buffer, launch the
// rasteriser and forward its pixels, owning the single framebuffer write port.
module frame_scheduler #(
    parameter int H_RES   = gfx_pkg::H_RES,
    parameter int V_RES   = gfx_pkg::V_RES,
    parameter int FB_AW   = gfx_pkg::FB_AW,
    parameter int COLOR_W = gfx_pkg::COLOR_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic               frame_en,
    input  logic [COLOR_W-1:0] bg_color,
    output logic               draw_start,
    input  logic               draw_done,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               draw_pixel_valid,
    input  logic [COLOR_W-1:0] draw_color,
    output logic               fb_we,
    output logic [FB_AW-1:0]   fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    output logic               fb_back_sel,
    output logic               busy,
    output logic               frame_overrun
);
    import gfx_pkg::*;

    localparam int               PIXELS    = H_RES * V_RES;
    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(PIXELS - 1);

    sched_state_t       state_q, state_d;
    logic [FB_AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [FB_AW-1:0]   fb_addr_q, fb_addr_d;
    logic [COLOR_W-1:0] fb_data_q, fb_data_d;
    logic               fb_we_q, fb_we_d;
    logic               draw_start_q, draw_start_d;
    logic               overrun_q, overrun_d;
    logic               back_sel_q, back_sel_d;
    logic [FB_AW-1:0]   pix_addr;
    logic               pix_in_range;
    logic               busy_w;

    fb_addr_gen #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .FB_AW (FB_AW)
    ) u_addr_gen (
        .x_i        (DrawX),
        .y_i        (DrawY),
        .addr_o     (pix_addr),
        .in_range_o (pix_in_range)
    );

    assign busy_w = (state_q == S_CLEAR) || (state_q == S_DRAW_START) ||
                    (state_q == S_DRAW_WAIT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            clr_cnt_q    <= '0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            fb_we_q      <= 1'b0;
            draw_start_q <= 1'b0;
            overrun_q    <= 1'b0;
            back_sel_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fb_we_q      <= fb_we_d;
            draw_start_q <= draw_start_d;
            overrun_q    <= overrun_d;
            back_sel_q   <= back_sel_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        fb_we_d      = 1'b0;
        draw_start_d = 1'b0;
        back_sel_d   = back_sel_q;
        // A tick while the frame is still being built is reported, never acted on.
        overrun_d    = frame_tick && busy_w;

        case (state_q)
            S_IDLE: begin
                if (frame_tick && frame_en) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            S_CLEAR: begin
                fb_we_d   = 1'b1;
                fb_addr_d = clr_cnt_q;
                fb_data_d = bg_color;
                clr_cnt_d = clr_cnt_q + FB_AW'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = S_DRAW_START;
                end
            end
            S_DRAW_START: begin
                draw_start_d = 1'b1;
                state_d      = S_DRAW_WAIT;
            end
            S_DRAW_WAIT: begin
                if (draw_pixel_valid && pix_in_range) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = pix_addr;
                    fb_data_d = draw_color;
                end
                if (draw_done) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (frame_tick) begin
                    back_sel_d = ~back_sel_q;
                    clr_cnt_d  = '0;
                    state_d    = frame_en ? S_CLEAR : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fb_we         = fb_we_q;
    assign fb_addr       = fb_addr_q;
    assign fb_data       = fb_data_q;
    assign draw_start    = draw_start_q;
    assign frame_overrun = overrun_q;
    assign fb_back_sel   = back_sel_q;
    assign busy          = busy_w;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler on an 8x4 frame: expected framebuffer
// writes are queued by the stimulus and popped by an independent monitor.
module tb_frame_scheduler;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int AW   = 8;
    localparam int CW   = 8;
    localparam int NPIX = H * V;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic          frame_en = 1'b0;
    logic [CW-1:0] bg_color = '0;
    logic          draw_start;
    logic          draw_done = 1'b0;
    logic [9:0]    DrawX = '0;
    logic [9:0]    DrawY = '0;
    logic          draw_pixel_valid = 1'b0;
    logic [CW-1:0] draw_color = '0;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [CW-1:0] fb_data;
    logic          fb_back_sel;
    logic          busy;
    logic          frame_overrun;

    frame_scheduler #(
        .H_RES   (H),
        .V_RES   (V),
        .FB_AW   (AW),
        .COLOR_W (CW)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .frame_tick       (frame_tick),
        .frame_en         (frame_en),
        .bg_color         (bg_color),
        .draw_start       (draw_start),
        .draw_done        (draw_done),
        .DrawX            (DrawX),
        .DrawY            (DrawY),
        .draw_pixel_valid (draw_pixel_valid),
        .draw_color       (draw_color),
        .fb_we            (fb_we),
        .fb_addr          (fb_addr),
        .fb_data          (fb_data),
        .fb_back_sel      (fb_back_sel),
        .busy             (busy),
        .frame_overrun    (frame_overrun)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  ov_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every framebuffer write must match the oldest expected one.
    initial begin
        wr_t e;
        forever begin
            @(negedge Clk);
            if (frame_overrun === 1'b1) ov_count++;
            if (fb_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %0h, expected no write",
                             fb_addr, fb_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("[MON] write addr=%0d data=%0h (exp %0d/%0h)",
                             fb_addr, fb_data, e.addr, e.data);
                    check("write_addr", 32'(fb_addr), e.addr);
                    check("write_data", 32'(fb_data), e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic drive_tick();
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    task automatic pulse_done();
        draw_done = 1'b1;
        @(negedge Clk);
        draw_done = 1'b0;
    endtask

    task automatic push_clear(input int n, input logic [CW-1:0] c);
        for (int i = 0; i < n; i++) exp_q.push_back('{addr: 32'(i), data: 32'(c)});
    endtask

    // Model: an accepted in-frame pixel lands at y*width + x.
    task automatic send_pixel(input int x, input int y, input logic [CW-1:0] c,
                              input logic done, input logic expect_wr);
        DrawX = 10'(x);
        DrawY = 10'(y);
        draw_color = c;
        draw_pixel_valid = 1'b1;
        draw_done = done;
        if (expect_wr && x < H && y < V)
            exp_q.push_back('{addr: 32'(y * H + x), data: 32'(c)});
        $display("[DRV] pixel x=%0d y=%0d c=%0h done=%0b", x, y, c, done);
        @(negedge Clk);
        draw_pixel_valid = 1'b0;
        draw_done = 1'b0;
    endtask

    task automatic draw_random(input int n);
        for (int i = 0; i < n; i++) begin
            int x;
            int y;
            x = int'($urandom_range(0, 9));
            y = int'($urandom_range(0, 5));
            send_pixel(x, y, CW'($urandom), 1'b0, 1'b1);
            if ($urandom_range(0, 1) == 1) step(1);
        end
    endtask

    task automatic wait_draw_start(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge Clk);
            if (draw_start === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int bad;
        int ov0;
        logic [CW-1:0] bg;

        // Reset state
        step(3);
        check("rst_fb_we", fb_we, 0);
        check("rst_draw_start", draw_start, 0);
        check("rst_busy", busy, 0);
        check("rst_back_sel", fb_back_sel, 0);
        check("rst_overrun", frame_overrun, 0);
        Reset = 1'b0;
        step(1);

        // Frame A: full clear with 1F, then draw
        frame_en = 1'b1;
        bg_color = 8'h1F;
        push_clear(NPIX, 8'h1F);
        drive_tick();
        bad = 0;
        for (int i = 1; i <= NPIX; i++) begin
            @(negedge Clk);
            if (busy !== 1'b1 || fb_back_sel !== 1'b0) bad++;
        end
        check("clear_busy_sel", 32'(bad), 0);
        wait_draw_start(cyc);
        check("draw_start_cycle_A", 32'(NPIX + cyc), NPIX + 1);
        check("clear_all_written", 32'(exp_q.size()), 0);
        send_pixel(3, 2, 8'hA5, 1'b0, 1'b1);
        check("draw_start_width", draw_start, 0);
        check("pix_3_2_we", fb_we, 1);
        check("pix_3_2_addr", 32'(fb_addr), 19);
        check("pix_3_2_data", 32'(fb_data), 32'h A5);
        send_pixel(8, 0, 8'h11, 1'b0, 1'b1);
        check("oob_x_we", fb_we, 0);
        send_pixel(0, 4, 8'h22, 1'b0, 1'b1);
        check("oob_y_we", fb_we, 0);
        draw_random(12);
        send_pixel(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)),
                   CW'($urandom), 1'b1, 1'b1);
        send_pixel(1, 1, 8'h77, 1'b0, 1'b0);
        step(2);
        check("ready_busy", busy, 0);

        // Frame B: swap on tick, overrun tick during clear
        ov0 = ov_count;
        bg = CW'($urandom);
        bg_color = bg;
        push_clear(NPIX, bg);
        drive_tick();
        check("swap1_sel", fb_back_sel, 1);
        step(4);
        check("no_overrun_on_swap", 32'(ov_count - ov0), 0);
        drive_tick();
        step(2);
        check("overrun_in_clear", 32'(ov_count - ov0), 1);
        check("overrun_no_swap", fb_back_sel, 1);
        wait_draw_start(cyc);
        check("draw_start_cycle_B", 32'(cyc), 26);
        draw_random(8);
        pulse_done();
        step(1);

        // Frame C: swap back, draw_done coincident with tick
        bg = CW'($urandom);
        bg_color = bg;
        push_clear(NPIX, bg);
        drive_tick();
        check("swap2_sel", fb_back_sel, 0);
        step(2);
        wait_draw_start(cyc);
        check("draw_start_cycle_C", 32'(cyc), 31);
        draw_random(6);
        ov0 = ov_count;
        frame_tick = 1'b1;
        draw_done = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        draw_done = 1'b0;
        step(2);
        check("overrun_with_done", 32'(ov_count - ov0), 1);
        check("done_tick_ready_busy", busy, 0);
        check("done_tick_no_swap", fb_back_sel, 0);

        // frame_en low at the READY tick: swap then idle
        frame_en = 1'b0;
        drive_tick();
        check("swap3_sel", fb_back_sel, 1);
        check("idle_busy", busy, 0);
        drive_tick();
        step(40);
        check("idle_tick_busy", busy, 0);
        check("idle_tick_sel", fb_back_sel, 1);

        // Reset in the middle of a clear
        frame_en = 1'b1;
        bg = CW'($urandom);
        bg_color = bg;
        push_clear(11, bg);
        drive_tick();
        check("no_swap_from_idle", fb_back_sel, 1);
        step(11);
        Reset = 1'b1;
        @(negedge Clk);
        check("midrst_fb_we", fb_we, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sel", fb_back_sel, 0);
        check("midrst_queue", 32'(exp_q.size()), 0);
        Reset = 1'b0;
        step(1);
        pulse_done();
        step(3);
        check("late_done_busy", busy, 0);

        // Restart: clear begins again at address 0
        bg = CW'($urandom);
        bg_color = bg;
        push_clear(NPIX, bg);
        drive_tick();
        wait_draw_start(cyc);
        check("draw_start_cycle_D", 32'(cyc), NPIX + 1);
        pulse_done();
        step(3);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
- Per-frame sequencer sitting between the vsync/timing logic, the triangle draw controller and a double-buffered framebuffer.
- On each frame tick it swaps front/back buffers and clears the back buffer to a background colour, one pixel per cycle.
- It then pulses draw_start to the draw controller and forwards that controller's pixel stream as framebuffer writes until draw_done.
- It owns the framebuffer write port, so the clear engine and the rasteriser never contend.

Parameters:
- H_RES, 640, horizontal resolution in pixels.
- V_RES, 480, vertical resolution in pixels.
- FB_AW, 19, framebuffer word address width; must satisfy 2^FB_AW >= H_RES*V_RES.
- COLOR_W, 8, pixel colour width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous reset, active-high.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- frame_en  in  1  rendering enable (level).
- bg_color  in  COLOR_W  clear colour, sampled each clear write.
- draw_start  out  1  one-cycle start pulse to draw controller.
- draw_done  in  1  one-cycle completion pulse from draw controller.
- DrawX  in  10  rasteriser pixel X.
- DrawY  in  10  rasteriser pixel Y.
- draw_pixel_valid  in  1  DrawX/DrawY/draw_color valid this cycle.
- draw_color  in  COLOR_W  rasteriser pixel colour.
- fb_we  out  1  framebuffer write enable.
- fb_addr  out  FB_AW  linear address, y*H_RES + x.
- fb_data  out  COLOR_W  write data.
- fb_back_sel  out  1  buffer currently being written; the display reads ~fb_back_sel.
- busy  out  1  high in CLEAR, DRAW_START and DRAW_WAIT.
- frame_overrun  out  1  one-cycle pulse when a tick arrives before the frame is ready.

Behaviour:
- Reset values:
  - state IDLE; all outputs 0; fb_back_sel 0; clear counter 0.
  - Reset mid-frame abandons the frame immediately. Any draw_done arriving after reset is ignored while in IDLE.
- States: IDLE, CLEAR, DRAW_START, DRAW_WAIT, READY.
- IDLE:
  - frame_tick & frame_en -> CLEAR, clear counter := 0, no swap.
  - frame_tick with frame_en low -> ignored.
- CLEAR:
  - Each cycle, registered write: fb_we=1, fb_addr=counter, fb_data=bg_color; counter increments.
  - After the write of address H_RES*V_RES-1 -> DRAW_START.
  - Exactly H_RES*V_RES writes, contiguous, one per cycle.
- DRAW_START: draw_start=1 for exactly one cycle -> DRAW_WAIT.
- DRAW_WAIT:
  - Each draw_pixel_valid with DrawX<H_RES and DrawY<V_RES produces one write one cycle later: fb_addr = DrawY*H_RES+DrawX (FB_AW bits, no truncation possible), fb_data = draw_color.
  - Out-of-range pixels are dropped (fb_we stays 0).
  - draw_done -> READY.
  - A pixel valid in the same cycle as draw_done is still written.
- READY:
  - frame_tick -> toggle fb_back_sel; then frame_en ? CLEAR (counter 0) : IDLE.
  - The swap is visible on fb_back_sel the cycle after the tick.
- Overrun:
  - frame_tick in CLEAR, DRAW_START or DRAW_WAIT -> frame_overrun=1 the next cycle. No swap, no state change; the frame completes and waits in READY for the following tick.
  - frame_tick coincident with draw_done in DRAW_WAIT counts as overrun and moves to READY.
- Ignored inputs:
  - draw_pixel_valid outside DRAW_WAIT is ignored.
  - draw_done outside DRAW_WAIT is ignored.
- Write latency: fb_we, fb_addr and fb_data are all registered, 1-cycle latency from the source event. fb_we is 0 in every cycle with no write.
- frame_en deassertion mid-frame does not abort; it takes effect at the READY tick.

Decomposition:
- Package gfx_pkg holds:
  - H_RES, V_RES, FB_AW, COLOR_W defaults;
  - FB_PIXELS = H_RES*V_RES;
  - typedef sched_state_t (the five states);
  - typedef pixel_t (COLOR_W logic).
- Sub-module fb_addr_gen: combinational x,y -> linear address plus in_range flag. It is shared with the display read path.

Test Plan:
- H_RES=8, V_RES=4; Reset, frame_en=1, tick -> 32 consecutive writes, addr 0..31, data=bg_color 8'h1F. draw_start pulses once at cycle 33. busy=1 throughout. fb_back_sel stays 0.
- In DRAW_WAIT, pixel (3,2) colour 8'hA5 -> next cycle fb_we=1, addr=19, data=A5. Pixel (8,0) -> no write. Pixel (0,4) -> no write.
- draw_done, then tick -> fb_back_sel 0->1, new CLEAR starts, frame_overrun stays 0.
- Tick during CLEAR -> frame_overrun pulses once, no swap. Clear and draw complete; the next tick swaps.
- frame_en=0 before the READY tick -> swap occurs, state IDLE, busy=0. A further tick with frame_en=0 -> no writes.
- Reset asserted mid-CLEAR (address 10) -> next cycle fb_we=0, busy=0, fb_back_sel=0. A late draw_done has no effect; the next enabled tick restarts the clear at address 0.
